// File: rtl/seven_seg_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment scanner.
// Glyphs are {a,b,c,d,e,f,g}, active-low (0 = segment lit).
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    function automatic logic [6:0] hex_to_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Purpose: nibble to active-low 7-segment glyph decoder.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = hex_to_glyph(nibble);

endmodule

// File: rtl/seven_seg_scanner.sv
// Purpose: time-multiplexed N-digit common-anode driver with dead time, LZ blanking, tear-free update.
// Latency: seg/anode registered, one cycle behind the prescaler slot/phase that produced them.
// Backpressure: none; load is a fire-and-forget strobe, display refreshes at a fixed frame rate.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int DIV_WIDTH    = 11,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [4*NUM_DIGITS-1:0]         digits_i,
    input  logic                            load,
    input  logic [NUM_DIGITS-1:0]           digit_en,
    input  logic                            lz_blank,
    output logic [6:0]                      seg,
    output logic [NUM_DIGITS-1:0]           anode,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
    output logic                            frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [DIV_WIDTH-1:0]  CNT_MAX    = '1;
    localparam logic [DIV_WIDTH-1:0]  CNT_PRE    = CNT_MAX - 1'b1;
    localparam logic [DIV_WIDTH-1:0]  BLANK_LAST = DIV_WIDTH'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0   = NUM_DIGITS'(1);

    logic [DIV_WIDTH-1:0]    cnt;
    logic [4*NUM_DIGITS-1:0] staging;
    logic [4*NUM_DIGITS-1:0] shadow;
    scan_state_t             state;

    logic       slot_wrap;
    logic       frame_wrap;
    logic       lz_dark;
    logic       digit_dark;
    logic [3:0] cur_nib;
    logic [6:0] cur_glyph;

    assign slot_wrap  = (cnt == CNT_MAX);
    assign frame_wrap = slot_wrap && (digit_idx == LAST_IDX);
    assign cur_nib    = shadow[{digit_idx, 2'b00} +: 4];

    // Shifting out the lower nibbles leaves exactly nibbles idx..N-1; all-zero means a leading zero.
    assign lz_dark    = lz_blank && (digit_idx != '0) && ((shadow >> {digit_idx, 2'b00}) == '0);
    assign digit_dark = !digit_en[digit_idx] || lz_dark;

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nib),
        .glyph  (cur_glyph)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            digit_idx   <= '0;
            state       <= BLANK;
            seg         <= SEG_BLANK;
            anode       <= '1;
            staging     <= '0;
            shadow      <= '0;
            frame_start <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (slot_wrap)
                digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;

            // Registered one cycle early so the pulse lines up with the frame-wrap cycle.
            frame_start <= (cnt == CNT_PRE) && (digit_idx == LAST_IDX);

            if (load)
                staging <= digits_i;
            if (frame_wrap)
                shadow <= load ? digits_i : staging;

            if (slot_wrap)
                state <= (BLANK_CYCLES == 0) ? SHOW : BLANK;
            else if (cnt == BLANK_LAST)
                state <= SHOW;

            if (state == SHOW && !digit_dark) begin
                seg   <= cur_glyph;
                anode <= ~(ONE_HOT0 << digit_idx);
            end else begin
                seg   <= SEG_BLANK;
                anode <= '1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized and directed checks of seven_seg_scanner against a cycle-count reference model.
module tb_seven_seg_scanner;

    localparam int ND    = 4;
    localparam int DW    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = 16;
    localparam int FRAME = ND * SLOT;

    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits_i = '0;
    logic        load = 1'b0;
    logic [3:0]  digit_en = 4'hF;
    logic        lz_blank = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  anode;
    logic [1:0]  digit_idx;
    logic        frame_start;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS   (ND),
        .DIV_WIDTH    (DW),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digits_i    (digits_i),
        .load        (load),
        .digit_en    (digit_en),
        .lz_blank    (lz_blank),
        .seg         (seg),
        .anode       (anode),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: t = cycles since reset release; slot/phase derive from t directly.
    int          t;
    logic [15:0] m_stg;
    logic [15:0] m_shd;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    int          exp_idx;
    logic        exp_fs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        t       = 0;
        m_stg   = '0;
        m_shd   = '0;
        exp_seg = 7'h7F;
        exp_an  = 4'hF;
        exp_idx = 0;
        exp_fs  = 1'b0;
    endtask

    // Called at a negedge: check outputs, drive inputs for the coming posedge, advance model.
    task automatic step(input logic ld, input logic [15:0] dig);
        int   slot;
        int   phase;
        logic lit;
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("anode", 32'(anode), 32'(exp_an));
        chk("digit_idx", 32'(digit_idx), 32'(exp_idx));
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
        chk("one_anode_max", 32'($countones(~anode) <= 1), 32'd1);

        load     = ld;
        digits_i = dig;

        slot  = (t / SLOT) % ND;
        phase = t % SLOT;
        lit   = (phase >= BC) && digit_en[slot] &&
                !(lz_blank && slot > 0 && (m_shd >> (4 * slot)) == 16'h0);
        exp_seg = lit ? GLYPH[4'(m_shd >> (4 * slot))] : 7'h7F;
        exp_an  = lit ? ~(4'b0001 << slot) : 4'hF;

        if (t % FRAME == FRAME - 1)
            m_shd = ld ? dig : m_stg;
        if (ld)
            m_stg = dig;

        t++;
        exp_idx = (t / SLOT) % ND;
        exp_fs  = (t % FRAME == FRAME - 1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'($urandom));
    endtask

    task automatic run_to(input int phase);
        while (t % FRAME != phase) step(1'b0, 16'($urandom));
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_idx", 32'(digit_idx), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        reset = 1'b0;

        // Reach a lit slot, then hit reset asynchronously in mid-cycle.
        idle(40);
        #2 reset = 1'b1;
        #1;
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_anode", 32'(anode), 32'hF);
        chk("arst_idx", 32'(digit_idx), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Basic load and display.
        step(1'b1, 16'h1234);
        idle(2 * FRAME);

        // Mid-frame load waits for the frame boundary; frame-wrap load bypasses.
        run_to(30);
        step(1'b1, 16'hABCD);
        run_to(FRAME - 1);
        step(1'b1, 16'h5678);
        idle(FRAME);

        // Leading-zero blanking.
        lz_blank = 1'b1;
        step(1'b1, 16'h0050);
        idle(2 * FRAME);
        step(1'b1, 16'h0000);
        idle(2 * FRAME);
        lz_blank = 1'b0;

        // Per-digit enable.
        digit_en = 4'b1010;
        step(1'b1, 16'h9ABC);
        idle(2 * FRAME);
        digit_en = 4'hF;

        // Every glyph on digit 0.
        for (int v = 0; v < 16; v++) begin
            run_to(FRAME - 1);
            step(1'b1, 16'(v));
            idle(FRAME - 1);
        end

        // Random traffic, biased toward leading zeros.
        repeat (20 * FRAME) begin
            if ($urandom_range(0, 63) == 0)
                digit_en = 4'($urandom);
            if ($urandom_range(0, 127) == 0)
                lz_blank = ~lz_blank;
            step($urandom_range(0, 15) == 0,
                 16'($urandom) >> (4 * $urandom_range(0, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
